// File: rtl/clk_div_pkg.sv
// Shared types and sizing helpers for the clk_div_gen clock-enable generator.
// Imported by the top module and by the per-channel sub-module.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ALIGN     = 2'd0,
        WAIT_LOCK = 2'd1,
        LOCKED    = 2'd2
    } state_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // Lock counter must be able to hold LOCK_CYC itself.
    function automatic int lock_w(input int lock_cyc);
        return (lock_cyc <= 1) ? 1 : $clog2(lock_cyc + 1);
    endfunction

    // A phase at or beyond the period clamps to the last slot of the period.
    function automatic logic [31:0] clamp_phase(input logic [31:0] div,
                                                input logic [31:0] phase);
        if (div == 32'd0) begin
            return 32'd0;
        end
        if (phase >= div) begin
            return div - 32'd1;
        end
        return phase;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase delay counter, position-in-period counter and the
// registered clk_en/clk_div outputs. Counters are preset while align_i is high.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             align_i,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] phase_i,
    output logic             clk_en_o,
    output logic             clk_div_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] dly_q, dly_d;
    logic [DIV_W-1:0] pos_q, pos_d;
    logic [DIV_W-1:0] dly_cur, pos_cur;
    logic [DIV_W-1:0] p_eff;
    logic [DIV_W:0]   half;
    logic             active;
    logic             en_q, en_d;
    logic             dv_q, dv_d;

    // The align cycle evaluates run cycle 0 directly from the preset values,
    // so the first registered output already belongs to k=0.
    always_comb begin
        p_eff   = DIV_W'(clamp_phase(32'(div_i), 32'(phase_i)));
        half    = ({1'b0, div_i} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        dly_cur = align_i ? p_eff : dly_q;
        pos_cur = align_i ? '0    : pos_q;
        active  = (dly_cur == '0);

        en_d = active && (pos_cur == '0) && (div_i != '0);
        dv_d = active && ({1'b0, pos_cur} < half) && (div_i != '0);
        if (clear_i) begin
            en_d = 1'b0;
            dv_d = 1'b0;
        end

        dly_d = '0;
        pos_d = '0;
        if (!active) begin
            dly_d = dly_cur - ONE;
        end else if (pos_cur != div_i - ONE) begin
            pos_d = pos_cur + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dly_q <= '0;
            pos_q <= '0;
            en_q  <= 1'b0;
            dv_q  <= 1'b0;
        end else begin
            dly_q <= dly_d;
            pos_q <= pos_d;
            en_q  <= en_d;
            dv_q  <= dv_d;
        end
    end

    assign clk_en_o  = en_q;
    assign clk_div_o = dv_q;

endmodule

// File: rtl/clk_div_gen.sv
// Runtime-reconfigurable multi-channel clock-enable / divided-clock generator.
// Holds the align/lock FSM, the config handshake and per-channel shadow registers.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  DIV_W    = 8,
    parameter int  LOCK_CYC = 16,
    parameter int  DEF_DIV  = 2,
    localparam int CH_W     = ch_w(NUM_CH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_div,
    output logic              locked,
    output state_e            dbg_state_o
);

    localparam int            LW       = lock_w(LOCK_CYC);
    localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_CYC - 1);

    state_e           state_q, state_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0] div_q   [NUM_CH];
    logic [DIV_W-1:0] div_d   [NUM_CH];
    logic [DIV_W-1:0] phase_q [NUM_CH];
    logic [DIV_W-1:0] phase_d [NUM_CH];
    logic             xfer;
    logic             align;
    logic             clear;

    // Handshake: a config word transfers on any rising edge where cfg_valid
    // and cfg_ready are both high; cfg_ready does not depend on cfg_valid.
    assign cfg_ready   = (state_q != ALIGN);
    assign locked      = (state_q == LOCKED);
    assign xfer        = cfg_valid && cfg_ready;
    assign align       = (state_q == ALIGN);
    assign clear       = (state_d == ALIGN);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ALIGN: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
            end
            WAIT_LOCK: begin
                if (lock_cnt_q == LOCK_TOP) begin
                    state_d = LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = ALIGN;
            end
        endcase
        // Every accepted config realigns all channels and restarts the lock count.
        if (xfer) begin
            state_d = ALIGN;
        end
    end

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (xfer && (cfg_ch == CH_W'(i))) begin
                div_d[i]   = cfg_div;
                phase_d[i] = cfg_phase;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ALIGN;
            lock_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DIV_W'(DEF_DIV);
                phase_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk_i     (sys_clk),
            .rst_i     (sys_rst),
            .align_i   (align),
            .clear_i   (clear),
            .div_i     (div_q[g]),
            .phase_i   (phase_q[g]),
            .clk_en_o  (clk_en[g]),
            .clk_div_o (clk_div[g])
        );
    end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
Parametrised, runtime-reconfigurable clock-enable/divided-clock generator with NUM_CH independent channels, all derived from a single fabric clock.
Next generation of the fixed-ratio clocking wrapper: each channel has a programmable divide ratio and phase offset, loaded through a valid/ready config port.
Provides a locked status that drops on every reconfiguration.
Sits behind the board clocking block; feeds clock enables to downstream slow-rate logic (25 MHz-class domains) without consuming extra MMCM outputs.

Parameters:
NUM_CH, 4, number of output channels (>=1)
DIV_W, 8, width of divide ratio and phase fields
LOCK_CYC, 16, run cycles after alignment before locked asserts (>=1)
DEF_DIV, 2, reset divide ratio of every channel (phase resets to 0)

Ports:
sys_clk  in  1  fabric clock; all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
cfg_valid  in  1  config request
cfg_ready  out  1  config accept; transfer when cfg_valid && cfg_ready
cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH))
cfg_div  in  DIV_W  divide ratio N; 0 = channel disabled
cfg_phase  in  DIV_W  phase offset P in sys_clk cycles
clk_en  out  NUM_CH  one-cycle enable pulse per channel, every N cycles
clk_div  out  NUM_CH  divided square wave per channel
locked  out  1  all channels aligned and stable

Behaviour:
- Reset (sys_rst=1 at an edge): shadow div=DEF_DIV and phase=0 for all channels; state=ALIGN.
  - Outputs next cycle: clk_en=0, clk_div=0, locked=0, cfg_ready=0.
  - Reset mid-operation has identical effect and discards any pending config.
- FSM states: ALIGN, WAIT_LOCK, LOCKED.
  - ALIGN lasts exactly 1 cycle. All channel counters are preset from shadow regs; outputs forced 0; cfg_ready=0. Next state is WAIT_LOCK.
  - WAIT_LOCK counts run cycles. When LOCK_CYC run cycles have elapsed, next state is LOCKED. locked=0, cfg_ready=1.
  - LOCKED: locked=1, cfg_ready=1.
- Run cycle k: k=0 is the first cycle after ALIGN; k counts up from there.
- Channel i output rule, with N = shadow div and P = effective phase:
  - clk_en[i]=1 iff k>=P and (k-P) mod N == 0.
  - clk_div[i]=1 iff k>=P and (k-P) mod N < ceil(N/2).
  - Both outputs are registered.
- Boundary cases:
  - N=0: channel outputs held 0.
  - N=1: clk_en and clk_div constant 1 from k=0; phase ignored.
  - P>=N: effective P = N-1 (clamp, not modulo).
- locked timing: rises at run cycle LOCK_CYC; no cycle-level delay beyond that.
- Config accept (valid&&ready in WAIT_LOCK or LOCKED):
  - Only channel cfg_ch shadow regs are written.
  - Next cycle is ALIGN: all channels realign, so inter-channel phase relationships always hold. locked drops with the ALIGN cycle and the lock count restarts.
  - cfg_ch >= NUM_CH: transfer accepted, no shadow written; realign still occurs.
  - cfg_valid held across ALIGN is not accepted there (ready=0); it is accepted at run cycle 0.
- Widths: counters DIV_W bits. ceil(N/2) computed as (N+1)>>1 in DIV_W+1 bits; no overflow at N=2^DIV_W-1.

Decomposition:
- Package clk_div_pkg holds:
  - state enum (ALIGN, WAIT_LOCK, LOCKED)
  - CH_W function
  - lock-counter width function clog2(LOCK_CYC+1)
  - phase-clamp function
- One sub-module, clk_div_chan: a single channel with counter, preset-on-align, clk_en/clk_div registers, and the N=0/N=1 special cases.
- The top module contains the FSM, config handshake and shadow regs, and generate-instantiates NUM_CH clk_div_chan.

Test Plan:
1. Release reset, defaults (N=2, P=0) -> every channel: clk_en=1 at k=0,2,4…; clk_div=1,0,1,0…; locked=1 from k=16; cfg_ready=1 from k=0.
2. After lock, cfg ch1 div=5 phase=2 -> one ALIGN cycle with outputs 0 and locked=0. Then ch1 clk_en at k=2,7,12; clk_div high at k=2-4 and 7-9; ch0 restarts with N=2 at k=0; locked re-rises at k=16.
3. cfg ch2 div=0 -> clk_en[2]=clk_div[2]=0 permanently. Then cfg ch2 div=1 phase=7 -> both constant 1 from k=0.
4. cfg ch3 div=4 phase=9 -> effective P=3: clk_en[3] at k=3,7,11; clk_div[3] high k=3-4 and 7-8.
5. Hold cfg_valid 2 cycles with different data -> first accepted, ALIGN (ready=0), second accepted at k=0, second ALIGN follows; final shadow holds both writes.
6. Assert sys_rst for 1 cycle at k=20 after reconfig -> next cycle all outputs 0, locked=0. Defaults restored: clk_en at k=0,2… after ALIGN.
